// File: rtl/arbitro_recurso.sv
// Two-requester display-resource arbiter: level priority, round-robin on ties, fixed hold window.
// Optional build macro ARB_PREEMPT_EN lets a strictly higher-level pending request cut a grant short.
module arbitro_recurso #(
    parameter int HOLD_CYCLES = 8
) (
    input  logic       CLK,
    input  logic       RST_n,
    input  logic       REQ_A,
    input  logic       REQ_B,
    input  logic [2:0] PERF_A,
    input  logic [2:0] PERF_B,
    input  logic [2:0] FUN_A,
    input  logic [2:0] FUN_B,
    output logic       GNT_A,
    output logic       GNT_B,
    output logic [2:0] FUN_OUT,
    output logic [1:0] NIVEL_OUT,
    output logic       BUSY,
    output logic       ERR_A,
    output logic       ERR_B,
    output logic       CONFLITO
);

    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT_A = 2'd1;
    localparam logic [1:0] ST_GRANT_B = 2'd2;
    localparam logic [1:0] ST_GAP     = 2'd3;

    // Level 0 marks a profile that is not one-hot.
    function automatic logic [1:0] perf_to_level(input logic [2:0] perf);
        logic [1:0] lvl;
        case (perf)
            3'b001:  lvl = 2'd1;
            3'b010:  lvl = 2'd2;
            3'b100:  lvl = 2'd3;
            default: lvl = 2'd0;
        endcase
        return lvl;
    endfunction

    logic [1:0]       state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             pend_a_r, pend_a_s, pend_b_r, pend_b_s;
    logic [2:0]       fun_a_r, fun_a_s, fun_b_r, fun_b_s;
    logic [1:0]       lvl_a_r, lvl_a_s, lvl_b_r, lvl_b_s;
    logic             last_b_r, last_b_s;
    logic [2:0]       fun_out_r, fun_out_s;
    logic [1:0]       nivel_out_r, nivel_out_s;
    logic             gnt_a_r, gnt_b_r, busy_r;
    logic             err_a_r, err_a_s, err_b_r, err_b_s;
    logic             conflito_r, conflito_s;
    logic             win_a_s;
    logic [1:0]       lvl_req_a_s, lvl_req_b_s;
    logic             preempt_a_s, preempt_b_s;

    // Next-state logic: request capture, decision and hold window.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        pend_a_s    = pend_a_r;
        pend_b_s    = pend_b_r;
        fun_a_s     = fun_a_r;
        fun_b_s     = fun_b_r;
        lvl_a_s     = lvl_a_r;
        lvl_b_s     = lvl_b_r;
        last_b_s    = last_b_r;
        fun_out_s   = fun_out_r;
        nivel_out_s = nivel_out_r;
        err_a_s     = 1'b0;
        err_b_s     = 1'b0;
        conflito_s  = 1'b0;
        win_a_s     = 1'b0;
        lvl_req_a_s = perf_to_level(PERF_A);
        lvl_req_b_s = perf_to_level(PERF_B);
        preempt_a_s = 1'b0;
        preempt_b_s = 1'b0;
`ifdef ARB_PREEMPT_EN
        // A grant that is already on its last cycle ends normally and is not re-queued.
        preempt_a_s = (state_r == ST_GRANT_A) && pend_b_r && (lvl_b_r > nivel_out_r) && (cnt_r != CNT_ZERO);
        preempt_b_s = (state_r == ST_GRANT_B) && pend_a_r && (lvl_a_r > nivel_out_r) && (cnt_r != CNT_ZERO);
`endif

        if (REQ_A && (state_r != ST_GRANT_A)) begin
            if (lvl_req_a_s != 2'd0) begin
                pend_a_s = 1'b1;
                fun_a_s  = FUN_A;
                lvl_a_s  = lvl_req_a_s;
            end else begin
                err_a_s = 1'b1;
            end
        end else begin
            err_a_s = 1'b0;
        end

        if (REQ_B && (state_r != ST_GRANT_B)) begin
            if (lvl_req_b_s != 2'd0) begin
                pend_b_s = 1'b1;
                fun_b_s  = FUN_B;
                lvl_b_s  = lvl_req_b_s;
            end else begin
                err_b_s = 1'b1;
            end
        end else begin
            err_b_s = 1'b0;
        end

        case (state_r)
            ST_IDLE: begin
                if (pend_a_r && pend_b_r) begin
                    conflito_s = (fun_a_r == fun_b_r);
                    if (lvl_a_r != lvl_b_r) begin
                        win_a_s = (lvl_a_r > lvl_b_r);
                    end else begin
                        win_a_s = last_b_r;
                    end
                end else begin
                    win_a_s = pend_a_r;
                end
                if (pend_a_r || pend_b_r) begin
                    cnt_s = CNT_LOAD;
                    if (win_a_s) begin
                        state_s     = ST_GRANT_A;
                        pend_a_s    = 1'b0;
                        fun_out_s   = fun_a_r;
                        nivel_out_s = lvl_a_r;
                        last_b_s    = 1'b0;
                    end else begin
                        state_s     = ST_GRANT_B;
                        pend_b_s    = 1'b0;
                        fun_out_s   = fun_b_r;
                        nivel_out_s = lvl_b_r;
                        last_b_s    = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GRANT_A: begin
                if ((cnt_r == CNT_ZERO) || preempt_a_s) begin
                    state_s     = ST_GAP;
                    cnt_s       = CNT_ZERO;
                    fun_out_s   = 3'd0;
                    nivel_out_s = 2'd0;
                    if (preempt_a_s) begin
                        pend_a_s = 1'b1;
                        fun_a_s  = fun_out_r;
                        lvl_a_s  = nivel_out_r;
                    end else begin
                        pend_a_s = pend_a_r;
                    end
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            ST_GRANT_B: begin
                if ((cnt_r == CNT_ZERO) || preempt_b_s) begin
                    state_s     = ST_GAP;
                    cnt_s       = CNT_ZERO;
                    fun_out_s   = 3'd0;
                    nivel_out_s = 2'd0;
                    if (preempt_b_s) begin
                        pend_b_s = 1'b1;
                        fun_b_s  = fun_out_r;
                        lvl_b_s  = nivel_out_r;
                    end else begin
                        pend_b_s = pend_b_r;
                    end
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            ST_GAP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s     = ST_IDLE;
                cnt_s       = CNT_ZERO;
                fun_out_s   = 3'd0;
                nivel_out_s = 2'd0;
            end
        endcase
    end

    // State and registered outputs; LAST comes out of reset pointing at B.
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            pend_a_r    <= 1'b0;
            pend_b_r    <= 1'b0;
            fun_a_r     <= 3'd0;
            fun_b_r     <= 3'd0;
            lvl_a_r     <= 2'd0;
            lvl_b_r     <= 2'd0;
            last_b_r    <= 1'b1;
            fun_out_r   <= 3'd0;
            nivel_out_r <= 2'd0;
            gnt_a_r     <= 1'b0;
            gnt_b_r     <= 1'b0;
            busy_r      <= 1'b0;
            err_a_r     <= 1'b0;
            err_b_r     <= 1'b0;
            conflito_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            pend_a_r    <= pend_a_s;
            pend_b_r    <= pend_b_s;
            fun_a_r     <= fun_a_s;
            fun_b_r     <= fun_b_s;
            lvl_a_r     <= lvl_a_s;
            lvl_b_r     <= lvl_b_s;
            last_b_r    <= last_b_s;
            fun_out_r   <= fun_out_s;
            nivel_out_r <= nivel_out_s;
            gnt_a_r     <= (state_s == ST_GRANT_A);
            gnt_b_r     <= (state_s == ST_GRANT_B);
            busy_r      <= (state_s != ST_IDLE);
            err_a_r     <= err_a_s;
            err_b_r     <= err_b_s;
            conflito_r  <= conflito_s;
        end
    end

    assign GNT_A     = gnt_a_r;
    assign GNT_B     = gnt_b_r;
    assign FUN_OUT   = fun_out_r;
    assign NIVEL_OUT = nivel_out_r;
    assign BUSY      = busy_r;
    assign ERR_A     = err_a_r;
    assign ERR_B     = err_b_r;
    assign CONFLITO  = conflito_r;

endmodule

// File: tb/tb_arbitro_recurso.sv
// Scoreboard bench for arbitro_recurso (HOLD_CYCLES=4): directed per-cycle vectors with
// hand-computed output words; a monitor pops and compares one word after every rising edge.
module tb_arbitro_recurso;

    logic       clk;
    logic       rst_n;
    logic       req_a, req_b;
    logic [2:0] perf_a, perf_b, fun_a, fun_b;
    logic       gnt_a, gnt_b, busy, err_a, err_b, conflito;
    logic [2:0] fun_out;
    logic [1:0] nivel_out;

    int n_vec  = 0;
    int n_miss = 0;

    // Output word: {gnt_a, gnt_b, fun[2:0], nivel[1:0], busy, err_a, err_b, conflito}
    logic [10:0] exp_q[$];
    string       tag_q[$];

    localparam logic [10:0] O_IDLE = 11'b000_0000_0000;
    localparam logic [10:0] O_GAP  = 11'b000_0000_1000;
    localparam logic [10:0] O_EA   = 11'b000_0000_0100;
    localparam logic [10:0] O_EB   = 11'b000_0000_0010;
    localparam logic [10:0] O_CF   = 11'b000_0000_0001;

    arbitro_recurso #(.HOLD_CYCLES(4)) dut (
        .CLK(clk), .RST_n(rst_n),
        .REQ_A(req_a), .REQ_B(req_b),
        .PERF_A(perf_a), .PERF_B(perf_b),
        .FUN_A(fun_a), .FUN_B(fun_b),
        .GNT_A(gnt_a), .GNT_B(gnt_b),
        .FUN_OUT(fun_out), .NIVEL_OUT(nivel_out),
        .BUSY(busy), .ERR_A(err_a), .ERR_B(err_b), .CONFLITO(conflito)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] ga(input logic [2:0] f, input logic [1:0] n);
        return {1'b1, 1'b0, f, n, 1'b1, 3'b000};
    endfunction

    function automatic logic [10:0] gb(input logic [2:0] f, input logic [1:0] n);
        return {1'b0, 1'b1, f, n, 1'b1, 3'b000};
    endfunction

    // Drive one cycle of inputs and queue the output word expected after the next rising edge.
    task automatic cyc(input logic ra, input logic [2:0] pa, input logic [2:0] fa,
                       input logic rb, input logic [2:0] pb, input logic [2:0] fb,
                       input logic [10:0] e, input string t);
        @(negedge clk);
        rst_n  = 1'b1;
        req_a  = ra; perf_a = pa; fun_a = fa;
        req_b  = rb; perf_b = pb; fun_b = fb;
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    task automatic nop(input logic [10:0] e, input string t);
        cyc(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0, e, t);
    endtask

    task automatic nopn(input int n, input logic [10:0] e, input string t);
        for (int i = 0; i < n; i++) nop(e, t);
    endtask

    task automatic rst_cyc(input string t);
        @(negedge clk);
        rst_n = 1'b0;
        req_a = 1'b0; perf_a = 3'd0; fun_a = 3'd0;
        req_b = 1'b0; perf_b = 3'd0; fun_b = 3'd0;
        exp_q.push_back(O_IDLE);
        tag_q.push_back(t);
    endtask

    // Monitor: compare the DUT output word shortly after each rising edge.
    always @(posedge clk) begin
        logic [10:0] act;
        logic [10:0] e;
        string       t;
        #1;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            t   = tag_q.pop_front();
            act = {gnt_a, gnt_b, fun_out, nivel_out, busy, err_a, err_b, conflito};
            n_vec++;
            if (act !== e) begin
                n_miss++;
                $display("FAIL %s @%0t: got gnt_a/gnt_b/fun/nivel/busy/ea/eb/cf=%b, expected %b",
                         t, $time, act, e);
            end
        end
    end

    initial begin
        int w;
        rst_n = 1'b0;
        req_a = 1'b0; perf_a = 3'd0; fun_a = 3'd0;
        req_b = 1'b0; perf_b = 3'd0; fun_b = 3'd0;

        // Reset and idle
        rst_cyc("reset");
        rst_cyc("reset");
        nopn(10, O_IDLE, "idle");

        // Tie, round-robin and conflict: two rounds, A wins both (LAST=B at each decision)
        for (int r = 0; r < 2; r++) begin
            cyc(1'b1, 3'b010, 3'd3, 1'b1, 3'b010, 3'd3, O_IDLE, "tie_req");
            nop(ga(3'd3, 2'd2) | O_CF, "tie_grant_a_conf");
            nopn(3, ga(3'd3, 2'd2), "tie_hold_a");
            nop(O_GAP, "tie_gap1");
            nop(O_IDLE, "tie_idle1");
            nopn(4, gb(3'd3, 2'd2), "tie_hold_b");
            nop(O_GAP, "tie_gap2");
            nop(O_IDLE, "tie_idle2");
        end

        // Single request; owner re-request during its grant is ignored
        cyc(1'b1, 3'b010, 3'b101, 1'b0, 3'd0, 3'd0, O_IDLE, "single_req");
        nop(ga(3'd5, 2'd2), "single_grant");
        cyc(1'b1, 3'b100, 3'd7, 1'b0, 3'd0, 3'd0, ga(3'd5, 2'd2), "single_owner_req");
        nopn(2, ga(3'd5, 2'd2), "single_hold");
        nop(O_GAP, "single_gap");
        nopn(3, O_IDLE, "single_no_regrant");

        // Priority: B (level 3) before A (level 1); A refreshed to level 2 / fun 4 while waiting
        cyc(1'b1, 3'b001, 3'd2, 1'b1, 3'b100, 3'd6, O_IDLE, "prio_req");
        nop(gb(3'd6, 2'd3), "prio_grant_b");
        cyc(1'b1, 3'b010, 3'd4, 1'b0, 3'd0, 3'd0, gb(3'd6, 2'd3), "prio_refresh_a");
        nopn(2, gb(3'd6, 2'd3), "prio_hold_b");
        nop(O_GAP, "prio_gap");
        nop(O_IDLE, "prio_idle");
        nopn(4, ga(3'd4, 2'd2), "prio_hold_a");
        nop(O_GAP, "prio_gap_a");
        nop(O_IDLE, "prio_idle_a");

        // Invalid profiles
        cyc(1'b1, 3'b011, 3'd1, 1'b0, 3'd0, 3'd0, O_EA, "err_a");
        nopn(2, O_IDLE, "err_a_no_grant");
        cyc(1'b0, 3'd0, 3'd0, 1'b1, 3'b000, 3'd2, O_EB, "err_b");
        nopn(2, O_IDLE, "err_b_no_grant");

        // A at level 1, B at level 3 arrives during grant cycle 1
        cyc(1'b1, 3'b001, 3'd1, 1'b0, 3'd0, 3'd0, O_IDLE, "pre_req_a");
        nop(ga(3'd1, 2'd1), "pre_grant_a");
        cyc(1'b0, 3'd0, 3'd0, 1'b1, 3'b100, 3'd7, ga(3'd1, 2'd1), "pre_req_b");
`ifdef ARB_PREEMPT_EN
        nop(O_GAP, "pre_gap");
        nop(O_IDLE, "pre_idle");
        nopn(4, gb(3'd7, 2'd3), "pre_hold_b");
        nop(O_GAP, "pre_gap_b");
        nop(O_IDLE, "pre_idle_b");
        nopn(4, ga(3'd1, 2'd1), "pre_reserve_a");
        nop(O_GAP, "pre_gap_a");
        nop(O_IDLE, "pre_idle_a");
`else
        nopn(2, ga(3'd1, 2'd1), "nopre_full_hold_a");
        nop(O_GAP, "nopre_gap");
        nop(O_IDLE, "nopre_idle");
        nopn(4, gb(3'd7, 2'd3), "nopre_hold_b");
        nop(O_GAP, "nopre_gap_b");
        nop(O_IDLE, "nopre_idle_b");
`endif

        // Reset mid-grant: outputs clear at once, pending B is lost
        cyc(1'b1, 3'b100, 3'd6, 1'b0, 3'd0, 3'd0, O_IDLE, "mid_req_a");
        nop(ga(3'd6, 2'd3), "mid_grant_a");
        cyc(1'b0, 3'd0, 3'd0, 1'b1, 3'b001, 3'd1, ga(3'd6, 2'd3), "mid_req_b");
        rst_cyc("mid_reset");
        nopn(4, O_IDLE, "mid_after_reset");

        w = 0;
        while (exp_q.size() > 0 && w < 10) begin
            @(posedge clk);
            #2;
            w++;
        end
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d vectors left unchecked, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/arbitro_recurso.md
# arbitro_recurso

- Sequential arbiter that shares the display resources (LEDs, LED matrix, 7-segment) between the two requesters, IE01 (A) and IE02 (B).
- Each requester latches a request carrying a one-hot profile and a 3-bit function code.
- The arbiter grants the resource to one requester at a time for a fixed hold window, decided by profile level with round-robin on ties.
- It sits between the switch/button decode and the LED/matrix/7-seg encoders and drives their function and profile selects.

## Interface
- HOLD_CYCLES, 8, cycles a grant is held (≥1); counter width is $clog2(HOLD_CYCLES+1).
- CLK  in  1  rising-edge clock
- RST_n  in  1  synchronous active-low reset
- REQ_A / REQ_B  in  1  request strobe (level sampled each edge)
- PERF_A / PERF_B  in  3  profile, one-hot: 001→level 1, 010→level 2, 100→level 3; anything else is invalid
- FUN_A / FUN_B  in  3  requested function code
- GNT_A / GNT_B  out  1  grant, mutually exclusive
- FUN_OUT  out  3  function of current owner, 0 when idle
- NIVEL_OUT  out  2  level of current owner, 0 when idle
- BUSY  out  1  high in GRANT_A, GRANT_B, GAP
- ERR_A / ERR_B  out  1  one-cycle pulse: request discarded for invalid profile
- CONFLITO  out  1  one-cycle pulse: both pending with equal FUN at a decision

## Operation
- **Pending registers.** PEND_X with captured PERF/FUN is set at the edge where REQ_X=1 and the profile is valid.
  - An invalid profile sets no pending bit and pulses ERR_X next cycle.
  - REQ_X while PEND_X=1 refreshes the captured FUN/level.
  - REQ_X from the current owner during its grant is ignored.
- **States:** IDLE, GRANT_A, GRANT_B, GAP.
- **IDLE, decision:**
  - No pending requester: stay in IDLE.
  - One pending: grant it.
  - Both pending: the higher level wins.
  - Equal levels: the winner is the requester that is not LAST; LAST resets to B, so A wins the first tie.
  - Equal FUN with both pending: pulse CONFLITO. Arbitration is unchanged.
- **On grant:**
  - Clear the winner's PEND.
  - Load FUN_OUT and NIVEL_OUT from its captured values; they stay stable for the whole grant.
  - Set LAST to the winner.
  - Load the hold counter with HOLD_CYCLES-1.
- **GRANT_X:**
  - Decrement the counter each cycle.
  - At 0, go to GAP.
- **GAP:** one cycle with GNT=0, FUN_OUT=0, NIVEL_OUT=0, then IDLE.
- **Loser:** its PEND stays set; it is served after GAP+IDLE.
- **Reset values:** all outputs 0, state IDLE, PEND_A=PEND_B=0, LAST=B, counter 0.
- **Reset mid-grant:** the grant drops at the next edge and pending requests are lost.

## Timing
- REQ high at edge k → PEND at edge k → state/GNT at edge k+1.
- GNT is visible from cycle k+2, so latency is 2 cycles from IDLE.
- GNT stays high for exactly HOLD_CYCLES cycles.
- Inter-grant gap is 2 cycles (GAP + IDLE decision).
- ERR_X and CONFLITO are registered and last exactly 1 cycle.
- Simultaneous REQ_A/REQ_B in the same cycle are arbitrated together at the next decision.

## Configuration
- **ARB_PREEMPT_EN defined:**
  - In GRANT_X, if the other requester is pending with a strictly higher level, go to GAP at the next edge regardless of the counter.
  - The preempted owner's request is re-queued: PEND_X is set with its current FUN/level.
- **ARB_PREEMPT_EN undefined:** no preemption; every grant runs the full HOLD_CYCLES.

## Test plan
- **Reset and idle:**
  - Stimulus: RST_n=0 for 2 cycles, then no REQ for 10 cycles.
  - Required: all outputs 0 throughout.
- **Single request:**
  - Stimulus: REQ_A=1 one cycle, PERF_A=010, FUN_A=3'b101, HOLD_CYCLES=4.
  - Required: GNT_A=1 from cycle +2 for 4 cycles, FUN_OUT=5, NIVEL_OUT=2, then GAP, BUSY=0.
- **Priority:**
  - Stimulus: same cycle REQ_A (PERF 001) and REQ_B (PERF 100).
  - Required: GNT_B first for 4 cycles, then 2-cycle gap, then GNT_A for 4 cycles.
- **Tie, round-robin and conflict:**
  - Stimulus: both level 2, FUN_A=FUN_B=3, repeated twice.
  - Required:
    - First round: A, then B; CONFLITO pulses once.
    - Second round: A again, since LAST=B after the first round.
- **Invalid profile:**
  - Stimulus: REQ_A with PERF_A=011.
  - Required: ERR_A pulses 1 cycle, no GNT_A. REQ_B with PERF_B=000 → ERR_B.
- **Preemption and reset mid-grant:**
  - With ARB_PREEMPT_EN:
    - Stimulus: A granted at level 1, REQ_B at level 3 on grant cycle 1.
    - Required: GAP next cycle, then GNT_B, then GNT_A re-served.
  - Without ARB_PREEMPT_EN: A holds the full 4 cycles.
  - Reset mid-grant: RST_n=0 during a grant → all outputs 0 at the next edge.
